// File: rtl/sha3_sponge_ctrl.sv
// SHA3-512 sponge sequencer: packs 64-bit words into 576-bit rate blocks, applies
// SHA3 padding, issues blocks to the Keccak core and captures the 512-bit digest.
module sha3_sponge_ctrl #(
    parameter int         RATE_WORDS = 9,
    parameter int         OUT_BITS   = 512,
    parameter logic [7:0] DOMAIN     = 8'h06
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [63:0]              in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic [3:0]               in_nbytes,
    output logic                     in_ready,
    output logic                     perm_rst_b,
    output logic [RATE_WORDS*64-1:0] perm_in,
    output logic                     perm_in_ready,
    input  logic [1599:0]            perm_out,
    input  logic                     perm_out_ready,
    output logic [OUT_BITS-1:0]      digest,
    output logic                     digest_valid,
    input  logic                     digest_ready
);

    localparam int                BLK_W   = RATE_WORDS * 64;
    localparam logic [3:0]        LAST_W  = 4'(RATE_WORDS - 1);
    localparam logic [BLK_W-1:0]  PAD_BLK = {DOMAIN, {(BLK_W-16){1'b0}}, 8'h80};

    typedef enum logic [2:0] {S_INIT, S_FILL, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t           state;
    logic [BLK_W-1:0] blk;
    logic [3:0]       wcnt;
    logic             more;
    logic             padblk;
    logic             perm_busy;

    logic [5:0]       shamt;
    logic [63:0]      keep_mask;
    logic [63:0]      word_in;
    logic [BLK_W-1:0] blk_acc;
    logic             short_last;
    logic             full_last;
    logic             unused_state_bits;

    assign perm_in    = blk;
    assign perm_rst_b = ~rst & (state != S_INIT);
    assign unused_state_bits = ^perm_out[1599-OUT_BITS:0];

    // Block image after absorbing the word on the input, including any padding it triggers
    always_comb begin
        shamt      = {in_nbytes[2:0], 3'b000};
        short_last = in_last && !in_nbytes[3];
        full_last  = in_last && in_nbytes[3] && (wcnt == LAST_W);
        keep_mask  = '1;
        if (short_last)
            keep_mask = ~({64{1'b1}} >> shamt);
        word_in = in_data & keep_mask;
        if (short_last)
            word_in = word_in | ({DOMAIN, 56'd0} >> shamt);
        blk_acc = blk;
        for (int k = 0; k < RATE_WORDS; k++)
            if (wcnt == 4'(k))
                blk_acc[BLK_W-1-64*k -: 64] = word_in;
        // A full final word pushes the domain byte into the start of the next word
        if (in_last && in_nbytes[3] && (wcnt != LAST_W))
            for (int k = 0; k < RATE_WORDS; k++)
                if (wcnt + 4'd1 == 4'(k))
                    blk_acc[BLK_W-1-64*k -: 8] = DOMAIN;
        if (in_last && !full_last)
            blk_acc[7:0] = blk_acc[7:0] | 8'h80;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_INIT;
            in_ready      <= 1'b0;
            perm_in_ready <= 1'b0;
            perm_busy     <= 1'b0;
            digest_valid  <= 1'b0;
            digest        <= '0;
            blk           <= '0;
            wcnt          <= '0;
            more          <= 1'b0;
            padblk        <= 1'b0;
        end else begin
            if (perm_out_ready)
                perm_busy <= 1'b0;
            case (state)
                S_INIT: begin
                    blk      <= '0;
                    wcnt     <= '0;
                    in_ready <= 1'b1;
                    state    <= S_FILL;
                end
                S_FILL: begin
                    if (in_valid && in_ready) begin
                        blk <= blk_acc;
                        if (in_last) begin
                            in_ready <= 1'b0;
                            more     <= full_last;
                            padblk   <= full_last;
                            state    <= S_ISSUE;
                        end else if (wcnt == LAST_W) begin
                            in_ready <= 1'b0;
                            more     <= 1'b1;
                            padblk   <= 1'b0;
                            state    <= S_ISSUE;
                        end else begin
                            wcnt <= wcnt + 4'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    // Buffer is cleared only after the strobe cycle so perm_in stays valid for it
                    if (perm_in_ready) begin
                        perm_in_ready <= 1'b0;
                        wcnt          <= '0;
                        if (padblk) begin
                            blk    <= PAD_BLK;
                            padblk <= 1'b0;
                            more   <= 1'b0;
                        end else begin
                            blk <= '0;
                            if (more) begin
                                in_ready <= 1'b1;
                                state    <= S_FILL;
                            end else begin
                                state <= S_WAIT;
                            end
                        end
                    end else if (!perm_busy) begin
                        perm_in_ready <= 1'b1;
                        perm_busy     <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (perm_out_ready) begin
                        digest       <= perm_out[1599 -: OUT_BITS];
                        digest_valid <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (digest_ready) begin
                        digest_valid <= 1'b0;
                        state        <= S_INIT;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule
